// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic valid/ready pipeline stage register for the 5-stage RISC-V core.
// Carries one payload (datapath field + control field) per transfer and can be
// dropped between any two stages (IF/ID, ID/IE, IE/IM, IM/IW) so that stall
// and flush behave the same everywhere.
//
// SKID=1 : two-entry skid buffer (main + skid register). in_ready comes
//          straight from a flop, which breaks the combinational
//          out_ready -> in_ready path through the pipeline.
// SKID=0 : single register, in_ready = !out_valid || out_ready.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (wins over flush)
//   flush      in   synchronous kill of every held entry
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept (transfer = in_valid && in_ready)
//   in_data    in   upstream datapath payload  [DATA_W]
//   in_ctrl    in   upstream control payload   [CTRL_W]
//   out_valid  out  downstream payload valid
//   out_ready  in   downstream accepts (pop = out_valid && out_ready)
//   out_data   out  downstream datapath payload [DATA_W]
//   out_ctrl   out  downstream control payload, 0 whenever out_valid=0
//   occupancy  out  entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W             = 101,
  parameter int CTRL_W             = 4,
  parameter bit SKID               = 1'b1,
  parameter bit ZERO_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic              in_ready_reg;

  logic accept;
  logic pop;

  assign out_valid = (state_reg != EMPTY);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  // SKID is a constant, so only one arm survives elaboration; with SKID=1
  // there is no logic path from out_ready to in_ready.
  assign in_ready  = SKID ? in_ready_reg : (!out_valid || out_ready);

  // The main register is always the head of the FIFO.
  assign out_data  = main_data_reg;

  // Gate control with valid so a bubble can never assert RegWrite/MemWrite,
  // even if main_ctrl_reg holds a stale value from a popped entry.
  assign out_ctrl  = out_valid ? main_ctrl_reg : '0;

  assign occupancy = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      in_ready_reg  <= 1'b1;
    end else if (flush) begin
      // Anything accepted this cycle is dropped along with the held entries.
      // A pop this cycle has already been seen downstream; nothing to undo.
      state_reg     <= EMPTY;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      in_ready_reg  <= 1'b1;
      if (ZERO_DATA_ON_FLUSH) begin
        main_data_reg <= '0;
      end
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_data_reg <= in_data;
            main_ctrl_reg <= in_ctrl;
            state_reg     <= ONE;
          end
        end

        ONE: begin
          case ({accept, pop})
            2'b10: begin
              // Head is stalled: park the new word in the skid entry.
              // Unreachable with SKID=0 because in_ready needs out_ready.
              if (SKID) begin
                skid_data_reg <= in_data;
                skid_ctrl_reg <= in_ctrl;
                state_reg     <= FULL;
                in_ready_reg  <= 1'b0;
              end
            end
            2'b01: begin
              state_reg <= EMPTY;
            end
            2'b11: begin
              // Replace the head in place: full throughput, no stall.
              main_data_reg <= in_data;
              main_ctrl_reg <= in_ctrl;
            end
            default: begin
            end
          endcase
        end

        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            main_data_reg <= skid_data_reg;
            main_ctrl_reg <= skid_ctrl_reg;
            state_reg     <= ONE;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg    <= EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 4;
  localparam int D0_W   = 16;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: SKID=1, ZERO_DATA_ON_FLUSH=1
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1'b1), .ZERO_DATA_ON_FLUSH(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  // Second DUT: SKID=0, ZERO_DATA_ON_FLUSH=0
  logic              d0_reset = 1'b1;
  logic              d0_flush = 1'b0;
  logic              d0_in_valid = 1'b0;
  logic              d0_in_ready;
  logic [D0_W-1:0]   d0_in_data = '0;
  logic [CTRL_W-1:0] d0_in_ctrl = '0;
  logic              d0_out_valid;
  logic              d0_out_ready = 1'b0;
  logic [D0_W-1:0]   d0_out_data;
  logic [CTRL_W-1:0] d0_out_ctrl;
  logic [1:0]        d0_occupancy;

  pipe_stage_reg #(
    .DATA_W(D0_W), .CTRL_W(CTRL_W), .SKID(1'b0), .ZERO_DATA_ON_FLUSH(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(d0_reset), .flush(d0_flush),
    .in_valid(d0_in_valid), .in_ready(d0_in_ready), .in_data(d0_in_data), .in_ctrl(d0_in_ctrl),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_data(d0_out_data), .out_ctrl(d0_out_ctrl),
    .occupancy(d0_occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a plain FIFO of accepted items, capacity 2.
  item_t q[$];
  bit    mon_en   = 1'b0;
  bit    zero_exp = 1'b0;   // out_data must read 0 while empty after reset/flush
  bit    last_acc = 1'b0;

  // Monitor: checks the visible state against the model mid-cycle and pops
  // whatever the downstream side consumes.
  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      n = q.size();
      chk("occupancy", occupancy, n);
      chk("out_valid", out_valid, n != 0);
      chk("in_ready", in_ready, n < 2);
      if (n != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_ctrl", out_ctrl, q[0].c);
        if (out_valid && out_ready) begin
          $display("pop  data=%0h ctrl=%0h occ=%0d", out_data, out_ctrl, occupancy);
          void'(q.pop_front());
        end
      end else begin
        chk("out_ctrl_bubble", out_ctrl, 0);
        if (zero_exp) chk("out_data_cleared", out_data, 0);
      end
    end
  end

  // One clock of stimulus on the main DUT. Inputs change 1 time unit after
  // the rising edge; the expected result is queued at the edge that commits it.
  task automatic cycle(input bit rs, input bit fl, input bit iv,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit ordy);
    reset = rs; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    @(negedge clk);
    last_acc = iv && in_ready;
    @(posedge clk);
    if (rs) begin
      q.delete(); zero_exp = 1'b1; mon_en = 1'b1;
    end else if (fl) begin
      q.delete(); zero_exp = 1'b1;
    end else if (last_acc) begin
      q.push_back('{d: d, c: c});
      zero_exp = 1'b0;
      $display("push data=%0h ctrl=%0h", d, c);
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  // Hold a word on the input until it is accepted, within a cycle budget.
  task automatic send(input logic [DATA_W-1:0] d, input bit ordy);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b0, 1'b1, d, d[CTRL_W-1:0], ordy);
      if (last_acc) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: data %0h not accepted, required acceptance within 16 cycles", d);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    @(posedge clk);
    #1;

    // Reset with a live upstream word that must not be captured.
    cycle(1'b1, 1'b0, 1'b1, DATA_W'(12'hABC), 4'hC, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, DATA_W'(12'hABC), 4'hC, 1'b0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_out_ctrl", out_ctrl, 0);

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, DATA_W'(8'h10 + i), 4'(i + 1), 1'b1);
    idle(); idle();

    // Backpressure fills both entries; the third word waits upstream.
    send(DATA_W'(8'h20), 1'b0);
    send(DATA_W'(8'h21), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, DATA_W'(8'h22), 4'h2, 1'b0);
    chk("bp_occupancy", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    send(DATA_W'(8'h22), 1'b1);
    idle(); idle(); idle();

    // Flush while FULL, with a concurrent transfer that must vanish.
    send(DATA_W'(8'h30), 1'b0);
    send(DATA_W'(8'h31), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, DATA_W'(8'h32), 4'h2, 1'b0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_occupancy", occupancy, 0);
    idle(); idle();

    // Reset and flush together while FULL.
    send(DATA_W'(8'h50), 1'b0);
    send(DATA_W'(8'h51), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, DATA_W'(8'h52), 4'h2, 1'b0);
    chk("prio_occupancy", occupancy, 0);
    chk("prio_in_ready", in_ready, 1);
    chk("prio_out_data", out_data, 0);

    // SKID=0 instance, directed.
    d0_reset = 1'b1; d0_in_valid = 1'b1; d0_in_data = 16'hABC;
    idle(); idle();
    d0_reset = 1'b0; d0_in_valid = 1'b0;
    #1;
    chk("d0_reset_valid", d0_out_valid, 0);
    chk("d0_reset_occ", d0_occupancy, 0);
    chk("d0_reset_in_ready", d0_in_ready, 1);
    chk("d0_reset_ctrl", d0_out_ctrl, 0);

    d0_in_valid = 1'b1; d0_in_data = 16'h40; d0_in_ctrl = 4'hA; d0_out_ready = 1'b0;
    idle();
    d0_in_valid = 1'b0;
    #1;
    chk("d0_load_valid", d0_out_valid, 1);
    chk("d0_load_data", d0_out_data, 16'h40);
    chk("d0_load_ctrl", d0_out_ctrl, 4'hA);
    chk("d0_load_occ", d0_occupancy, 1);
    chk("d0_stall_in_ready", d0_in_ready, 0);
    idle();
    chk("d0_hold_data", d0_out_data, 16'h40);

    // in_ready follows out_ready within the same cycle.
    d0_in_valid = 1'b1; d0_in_data = 16'h31; d0_in_ctrl = 4'h5;
    #1;
    chk("d0_comb_ready_low", d0_in_ready, 0);
    d0_out_ready = 1'b1;
    #1;
    chk("d0_comb_ready_high", d0_in_ready, 1);
    idle();
    d0_in_valid = 1'b0; d0_out_ready = 1'b0;
    #1;
    chk("d0_accpop_occ", d0_occupancy, 1);
    chk("d0_accpop_data", d0_out_data, 16'h31);
    chk("d0_accpop_ctrl", d0_out_ctrl, 4'h5);

    // Flush without data clear: data holds, valid/ctrl drop, new word dropped.
    d0_flush = 1'b1; d0_in_valid = 1'b1; d0_in_data = 16'h32; d0_in_ctrl = 4'h7;
    idle();
    d0_flush = 1'b0; d0_in_valid = 1'b0;
    #1;
    chk("d0_flush_valid", d0_out_valid, 0);
    chk("d0_flush_ctrl", d0_out_ctrl, 0);
    chk("d0_flush_occ", d0_occupancy, 0);
    chk("d0_flush_data_hold", d0_out_data, 16'h31);
    chk("d0_flush_in_ready", d0_in_ready, 1);

    // Reset mid-transfer drops the held entry and clears data.
    d0_in_valid = 1'b1; d0_in_data = 16'h55; d0_in_ctrl = 4'hF;
    idle();
    d0_reset = 1'b1; d0_in_data = 16'h66;
    idle();
    d0_reset = 1'b0; d0_in_valid = 1'b0;
    #1;
    chk("d0_rst_mid_valid", d0_out_valid, 0);
    chk("d0_rst_mid_occ", d0_occupancy, 0);
    chk("d0_rst_mid_data", d0_out_data, 0);

    // Randomized traffic on the main DUT against the FIFO model.
    begin
      int pct;
      pct = 50;
      for (int i = 0; i < 3000; i++) begin
        logic [DATA_W-1:0] d;
        if (i % 64 == 0) pct = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(5, 95);
        d = rnd_data();
        cycle($urandom_range(0, 255) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 3) != 0, d, d[CTRL_W-1:0] ^ 4'(i),
              $urandom_range(0, 99) < pct);
      end
    end
    for (int i = 0; i < 4; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
